logic_unit_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-cycle logic unit in the ALU.
- Eight bitwise operations selected by a 3-bit function code.
- Valid/ready handshake on input and output; full back-pressure; throughput of one op per clock.
- Registered result with zero and parity flags; sits between the ALU decoder and the ALU result mux.

---
 rtl/logic_unit_pipe.sv | 170 +++++++++++++++++
 tb/tb_logic_unit_pipe.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage pipelined bitwise logic unit with valid/ready
// handshake on both sides, registered result plus zero and parity flags.
// Optional completed-op counter on Op_Count, enabled by LOGIC_PIPE_CNT_EN.
module logic_unit_pipe #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           ALU_FUN,
    input  logic                 In_Valid,
    output logic                 In_Ready,
    output logic [WIDTH-1:0]     Logic_OUT,
    output logic                 Logic_Flag,
    input  logic                 Out_Ready,
    output logic                 Zero_Flag,
    output logic                 Parity_Flag
`ifdef LOGIC_PIPE_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] Op_Count
`endif
);

    // Parameter sanity checks, evaluated at elaboration.
    if (WIDTH < 2) begin : g_bad_width
        $error("logic_unit_pipe: WIDTH must be at least 2");
    end
    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
        $error("logic_unit_pipe: CNT_WIDTH must be at least 1");
    end

    // All eight codes are defined, so no fall-through value is needed.
    function automatic logic [WIDTH-1:0] logic_op(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [2:0]       fun
    );
        logic [WIDTH-1:0] r;
        case (fun)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b010:  r = ~(a & b);
            3'b011:  r = ~(a | b);
            3'b100:  r = a ^ b;
            3'b101:  r = ~(a ^ b);
            3'b110:  r = ~a;
            default: r = b;
        endcase
        return r;
    endfunction

    function automatic logic zero_of(input logic [WIDTH-1:0] r);
        return (r == '0);
    endfunction

    function automatic logic parity_of(input logic [WIDTH-1:0] r);
        return ^r;
    endfunction

    // Stage 1 registers
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [2:0]       s1_fun_q, s1_fun_d;
    logic             s1_vld_q, s1_vld_d;

    // Stage 2 registers
    logic [WIDTH-1:0] s2_res_q, s2_res_d;
    logic             s2_zero_q, s2_zero_d;
    logic             s2_par_q, s2_par_d;
    logic             s2_vld_q, s2_vld_d;

    logic             s2_adv;
    logic [WIDTH-1:0] s1_res;

    // S2 can take a new entry when empty or when its current result leaves.
    assign s2_adv   = !s2_vld_q || Out_Ready;
    assign In_Ready = !s1_vld_q || s2_adv;
    assign s1_res   = logic_op(s1_a_q, s1_b_q, s1_fun_q);

    // Next-state for both stages; S2 keeps its last result on drain.
    always_comb begin
        s1_a_d    = s1_a_q;
        s1_b_d    = s1_b_q;
        s1_fun_d  = s1_fun_q;
        s1_vld_d  = s1_vld_q;
        s2_res_d  = s2_res_q;
        s2_zero_d = s2_zero_q;
        s2_par_d  = s2_par_q;
        s2_vld_d  = s2_vld_q;

        if (In_Ready) begin
            s1_vld_d = In_Valid;
            if (In_Valid) begin
                s1_a_d   = A;
                s1_b_d   = B;
                s1_fun_d = ALU_FUN;
            end
        end

        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_res_d  = s1_res;
                s2_zero_d = zero_of(s1_res);
                s2_par_d  = parity_of(s1_res);
            end
        end
    end

    // ---- stage 1 boundary: operands and opcode captured ----
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_fun_q <= '0;
            s1_vld_q <= 1'b0;
        end else begin
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s1_fun_q <= s1_fun_d;
            s1_vld_q <= s1_vld_d;
        end
    end

    // ---- stage 2 boundary: result and flags registered ----
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s2_res_q  <= '0;
            s2_zero_q <= 1'b0;
            s2_par_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
        end else begin
            s2_res_q  <= s2_res_d;
            s2_zero_q <= s2_zero_d;
            s2_par_q  <= s2_par_d;
            s2_vld_q  <= s2_vld_d;
        end
    end

    assign Logic_OUT   = s2_res_q;
    assign Zero_Flag   = s2_zero_q;
    assign Parity_Flag = s2_par_q;
    assign Logic_Flag  = s2_vld_q;

`ifdef LOGIC_PIPE_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Count each output transfer; wraps naturally at the counter width.
    always_comb begin
        cnt_d = cnt_q;
        if (s2_vld_q && Out_Ready) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Completed-op counter register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Op_Count = cnt_q;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Testbench for logic_unit_pipe: directed steps plus randomized traffic,
// checked against a queue-based transaction model of the two-slot pipeline.
module tb_logic_unit_pipe;

    localparam int W  = 16;
    localparam int CW = 2;

    logic          CLK;
    logic          RST;
    logic [W-1:0]  A, B;
    logic [2:0]    ALU_FUN;
    logic          In_Valid, In_Ready;
    logic [W-1:0]  Logic_OUT;
    logic          Logic_Flag, Out_Ready, Zero_Flag, Parity_Flag;
`ifdef LOGIC_PIPE_CNT_EN
    logic [CW-1:0] Op_Count;
`endif

    logic_unit_pipe #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .A          (A),
        .B          (B),
        .ALU_FUN    (ALU_FUN),
        .In_Valid   (In_Valid),
        .In_Ready   (In_Ready),
        .Logic_OUT  (Logic_OUT),
        .Logic_Flag (Logic_Flag),
        .Out_Ready  (Out_Ready),
        .Zero_Flag  (Zero_Flag),
        .Parity_Flag(Parity_Flag)
`ifdef LOGIC_PIPE_CNT_EN
        ,
        .Op_Count   (Op_Count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] res;
        int           age;
    } item_t;

    item_t         q[$];
    logic [W-1:0]  last_out;
    logic [CW-1:0] exp_cnt;
    int            checks;
    int            failures;

    // Reference operation table.
    function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] f);
        case (f)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return ~(a & b);
            3'd3: return ~(a | b);
            3'd4: return a ^ b;
            3'd5: return ~(a ^ b);
            3'd6: return ~a;
            default: return b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model,
    // advance through the rising edge, update the model, return at negedge.
    task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f,
                        input logic iv, input logic ordy);
        logic flag_exp, rdy_exp, acc, xfer;
        A = a; B = b; ALU_FUN = f; In_Valid = iv; Out_Ready = ordy;
        #1;
        // Front entry reaches the output two edges after it was presented.
        flag_exp = (q.size() > 0) && (q[0].age >= 2);
        rdy_exp  = !((q.size() == 2) && !ordy);
        chk("in_ready", In_Ready, rdy_exp);
        chk("logic_flag", Logic_Flag, flag_exp);
        if (flag_exp) begin
            chk("logic_out", Logic_OUT, q[0].res);
            chk("zero_flag", Zero_Flag, q[0].res == 0);
            chk("parity_flag", Parity_Flag, ^q[0].res);
        end else begin
            chk("logic_out_hold", Logic_OUT, last_out);
        end
`ifdef LOGIC_PIPE_CNT_EN
        chk("op_count", Op_Count, exp_cnt);
`endif
        acc  = iv && rdy_exp;
        xfer = flag_exp && ordy;
        @(posedge CLK);
        if (xfer) begin
            last_out = q[0].res;
            void'(q.pop_front());
            exp_cnt = exp_cnt + 1'b1;
        end
        foreach (q[i]) q[i].age++;
        if (acc) q.push_back('{res: ref_op(a, b, f), age: 1});
        @(negedge CLK);
    endtask

    task automatic idle(input logic ordy);
        step(16'h0, 16'h0, 3'd0, 1'b0, ordy);
    endtask

    initial begin
        checks = 0; failures = 0;
        last_out = '0; exp_cnt = '0;
        A = '0; B = '0; ALU_FUN = '0;
        RST = 1'b0; In_Valid = 1'b1; Out_Ready = 1'b1;

        // Reset held with traffic pending on the inputs.
        repeat (3) @(negedge CLK);
        chk("rst_logic_out", Logic_OUT, 0);
        chk("rst_logic_flag", Logic_Flag, 0);
        chk("rst_zero", Zero_Flag, 0);
        chk("rst_parity", Parity_Flag, 0);
`ifdef LOGIC_PIPE_CNT_EN
        chk("rst_op_count", Op_Count, 0);
`endif
        In_Valid = 1'b0;
        RST = 1'b1;
        #1;
        chk("rel_in_ready", In_Ready, 1);
        chk("rel_logic_flag", Logic_Flag, 0);

        // Opcode sweep, back to back.
        for (int op = 0; op < 8; op++) step(16'hF0F0, 16'hFF00, op[2:0], 1'b1, 1'b1);
        repeat (3) idle(1'b1);

        // Flag cases with directed expected values.
        step(16'h00FF, 16'hFF00, 3'd0, 1'b1, 1'b1);
        step(16'h00FF, 16'hFF00, 3'd4, 1'b1, 1'b1);
        chk("and_out", Logic_OUT, 16'h0000);
        chk("and_zero", Zero_Flag, 1);
        chk("and_parity", Parity_Flag, 0);
        step(16'h0001, 16'h0007, 3'd7, 1'b1, 1'b1);
        chk("xor_out", Logic_OUT, 16'hFFFF);
        chk("xor_zero", Zero_Flag, 0);
        chk("xor_parity", Parity_Flag, 0);
        idle(1'b1);
        chk("pass_out", Logic_OUT, 16'h0007);
        chk("pass_zero", Zero_Flag, 0);
        chk("pass_parity", Parity_Flag, 1);
        repeat (2) idle(1'b1);

        // Back-pressure: 4 ops, Out_Ready low for 5 cycles once the first is valid.
        step(16'h1111, 16'h2222, 3'd1, 1'b1, 1'b1);
        step(16'h3333, 16'h0F0F, 3'd4, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(16'hAAAA, 16'h5555, 3'd5, 1'b1, 1'b0);
        step(16'hAAAA, 16'h5555, 3'd5, 1'b1, 1'b1);
        step(16'hC3C3, 16'h0000, 3'd6, 1'b1, 1'b1);
        repeat (4) idle(1'b1);

        // Reset mid-stream with both stages full.
        step(16'h0101, 16'h1010, 3'd1, 1'b1, 1'b1);
        step(16'h0202, 16'h2020, 3'd1, 1'b1, 1'b0);
        idle(1'b0);
        chk("pre_rst_flag", Logic_Flag, 1);
        RST = 1'b0;
        #1;
        chk("mid_rst_flag", Logic_Flag, 0);
        chk("mid_rst_out", Logic_OUT, 0);
        q.delete(); last_out = '0; exp_cnt = '0;
        @(negedge CLK);
        RST = 1'b1;
        step(16'h1234, 16'h00FF, 3'd1, 1'b1, 1'b1);
        idle(1'b1);
        chk("post_rst_out", Logic_OUT, 16'h12FF);
        chk("post_rst_flag", Logic_Flag, 1);
        repeat (2) idle(1'b1);

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            step(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
        end
        repeat (4) idle(1'b1);
        chk("drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
